// File: rtl/logic32_sched_if.sv
// Bundles the two requester handshakes and the shared 16-bit logic-unit bus of logic32_sched.
// The scheduler uses the slave modport; the requesters and the logic unit sit on the master side.
interface logic32_sched_if;
    logic        req0;
    logic        req1;
    logic [1:0]  op0;
    logic [1:0]  op1;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        ack0;
    logic        ack1;
    logic [15:0] dp_a;
    logic [15:0] dp_b;
    logic [1:0]  dp_op;
    logic [15:0] dp_f;
    logic        busy;
    logic        done;
    logic        done_id;
    logic [31:0] result;

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1, dp_f,
        output ack0, ack1, dp_a, dp_b, dp_op, busy, done, done_id, result
    );

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1, dp_f,
        input  ack0, ack1, dp_a, dp_b, dp_op, busy, done, done_id, result
    );
endinterface

// File: rtl/logic32_sched.sv
// Two-requester scheduler that runs 32-bit bitwise ops through one shared 16-bit logic unit,
// low half then high half, with round-robin or fixed-priority arbitration.
module logic32_sched #(
    parameter bit RR_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    logic32_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic        id_q, id_d;
    logic        last_q, last_d;
    logic [15:0] stage_lo_q, stage_lo_d;
    logic [31:0] result_q, result_d;
    logic        done_id_q, done_id_d;
    logic        grant;
    logic        winner;

    // rst_n gates the grant so no ack escapes while reset holds the FSM in IDLE.
    always_comb begin
        winner = bus.req1;
        if (bus.req0 && bus.req1) begin
            winner = RR_EN ? ~last_q : 1'b0;
        end
        grant = (state_q == IDLE) && (bus.req0 || bus.req1) && rst_n;
    end

    // NOTE: every variable gets its default first, so no path through the case leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        id_d       = id_q;
        last_d     = last_q;
        stage_lo_d = stage_lo_q;
        result_d   = result_q;
        done_id_d  = done_id_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = LO;
                    a_d     = winner ? bus.a1 : bus.a0;
                    b_d     = winner ? bus.b1 : bus.b0;
                    op_d    = winner ? bus.op1 : bus.op0;
                    id_d    = winner;
                    last_d  = winner;
                end
            end
            LO: begin
                state_d    = HI;
                stage_lo_d = bus.dp_f;
            end
            HI: begin
                // The high half lands straight in the output register, which then holds
                // until the next operation reaches DONE.
                state_d   = DONE;
                result_d  = {bus.dp_f, stage_lo_q};
                done_id_d = id_q;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.dp_a  = '0;
        bus.dp_b  = '0;
        bus.dp_op = '0;
        if (state_q == LO) begin
            bus.dp_a  = a_q[15:0];
            bus.dp_b  = b_q[15:0];
            bus.dp_op = op_q;
        end else if (state_q == HI) begin
            bus.dp_a  = a_q[31:16];
            bus.dp_b  = b_q[31:16];
            bus.dp_op = op_q;
        end
    end

    assign bus.ack0    = grant && !winner;
    assign bus.ack1    = grant && winner;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.done_id = done_id_q;
    assign bus.result  = result_q;

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values of its peers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            id_q       <= 1'b0;
            last_q     <= 1'b1;
            stage_lo_q <= '0;
            result_q   <= '0;
            done_id_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            id_q       <= id_d;
            last_q     <= last_d;
            stage_lo_q <= stage_lo_d;
            result_q   <= result_d;
            done_id_q  <= done_id_d;
        end
    end
endmodule
